// File: rtl/otter_muldiv.sv
// otter_muldiv: iterative RV32M multiply/divide unit for the OTTER core.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, funct3     request (sampled only when idle) and M-extension op select
//   rs1, rs2, rd      operands and destination index from the register file
//   busy              high from the cycle after accept through the done cycle
//   done              one-cycle completion pulse; wd/wa/en valid with it
//   wd, wa, en        register file write data, address and enable (en=0 for x0)
module otter_muldiv #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [4:0]      rd,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] wd,
  output logic [4:0]      wa,
  output logic            en
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [32:0] a_q, a_d;       // multiplier / dividend magnitude
  logic [32:0] b_q, b_d;       // multiplicand / divisor magnitude
  logic [63:0] acc_q, acc_d;   // product accumulator, or quotient in [31:0]
  logic [31:0] rem_q, rem_d;
  logic        neg_q, neg_d;   // negate product / quotient
  logic        sa_q, sa_d;     // rs1 was negative: remainder sign
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        en_q, en_d;
  logic [31:0] wd_q, wd_d;
  logic [4:0]  wa_q, wa_d;

  logic        sgn_a_c, sgn_b_c, fast_c;
  logic [32:0] mag_a_c, mag_b_c;
  logic [31:0] fast_res_c;
  logic [63:0] mul_acc_c, prod_c;
  logic [32:0] rem_sh_c;
  logic        rem_ge_c;
  logic [31:0] rem_nx_c, quo_c, rmd_c, res_c;
  logic [63:0] quo_nx_c;

  // Operand signedness, magnitudes and divide fast-path detection at accept
  always_comb begin
    sgn_a_c = rs1[31] & ((funct3 == 3'd1) | (funct3 == 3'd2) |
                         (funct3 == 3'd4) | (funct3 == 3'd6));
    sgn_b_c = rs2[31] & ((funct3 == 3'd1) | (funct3 == 3'd4) | (funct3 == 3'd6));
    // Sign-extend to 33 bits before negating so -2^31 maps to +2^31
    mag_a_c = sgn_a_c ? (33'd0 - {1'b1, rs1}) : {1'b0, rs1};
    mag_b_c = sgn_b_c ? (33'd0 - {1'b1, rs2}) : {1'b0, rs2};
    fast_c  = funct3[2] & ((rs2 == 32'd0) |
              (~funct3[0] & (rs1 == 32'h8000_0000) & (rs2 == 32'hFFFF_FFFF)));
    if (rs2 == 32'd0) fast_res_c = funct3[1] ? rs1 : 32'hFFFF_FFFF;
    else              fast_res_c = funct3[1] ? 32'd0 : 32'h8000_0000;
  end

  // One iteration of shift-add multiply / restoring divide, plus final sign fixup
  always_comb begin
    mul_acc_c = acc_q + (a_q[0] ? (64'(b_q) << cnt_q) : 64'd0);
    rem_sh_c  = {rem_q, a_q[31]};
    rem_ge_c  = (rem_sh_c >= b_q);
    rem_nx_c  = rem_ge_c ? 32'(rem_sh_c - b_q) : rem_sh_c[31:0];
    quo_nx_c  = {acc_q[62:0], rem_ge_c};
    prod_c    = neg_q ? (64'd0 - mul_acc_c) : mul_acc_c;
    quo_c     = neg_q ? (32'd0 - quo_nx_c[31:0]) : quo_nx_c[31:0];
    rmd_c     = sa_q ? (32'd0 - rem_nx_c) : rem_nx_c;
    if (op_q[2])             res_c = op_q[1] ? rmd_c : quo_c;
    else if (op_q == 3'd0)   res_c = prod_c[31:0];
    else                     res_c = prod_c[63:32];
  end

  // Next-state and output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    neg_d   = neg_q;
    sa_d    = sa_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    en_d    = 1'b0;
    wd_d    = wd_q;
    wa_d    = wa_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d   = funct3;
          a_d    = mag_a_c;
          b_d    = mag_b_c;
          acc_d  = 64'd0;
          rem_d  = 32'd0;
          neg_d  = sgn_a_c ^ sgn_b_c;
          sa_d   = sgn_a_c;
          cnt_d  = 5'd0;
          wa_d   = rd;
          busy_d = 1'b1;
          if (fast_c) begin
            state_d = FIN;
            done_d  = 1'b1;
            en_d    = (rd != 5'd0);
            wd_d    = fast_res_c;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q + 5'd1;
        if (op_q[2]) begin
          acc_d = quo_nx_c;
          rem_d = rem_nx_c;
          a_d   = {a_q[31:0], 1'b0};
        end else begin
          acc_d = mul_acc_c;
          a_d   = {1'b0, a_q[32:1]};
        end
        if (cnt_q == 5'd31) begin
          state_d = FIN;
          done_d  = 1'b1;
          en_d    = (wa_q != 5'd0);
          wd_d    = res_c;
        end
      end
      FIN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        cnt_d   = 5'd0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      op_q    <= 3'd0;
      a_q     <= 33'd0;
      b_q     <= 33'd0;
      acc_q   <= 64'd0;
      rem_q   <= 32'd0;
      neg_q   <= 1'b0;
      sa_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      en_q    <= 1'b0;
      wd_q    <= 32'd0;
      wa_q    <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      neg_q   <= neg_d;
      sa_q    <= sa_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      en_q    <= en_d;
      wd_q    <= wd_d;
      wa_q    <= wa_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign en   = en_q;
  assign wd   = wd_q;
  assign wa   = wa_q;

endmodule

// File: tb/tb_otter_muldiv.sv
// Self-checking bench for otter_muldiv: directed table, handshake/reset
// sequences and randomized ops against an arithmetic reference model.
module tb_otter_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2;
  logic [4:0]  rd;
  logic        busy, done, en;
  logic [31:0] wd;
  logic [4:0]  wa;

  int vectors = 0;
  int miscompares = 0;

  otter_muldiv #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .rs1(rs1), .rs2(rs2), .rd(rd),
    .busy(busy), .done(done), .wd(wd), .wa(wa), .en(en)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: RISC-V M semantics from plain 64-bit arithmetic
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, ub, p;
    logic [63:0] u;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = longint'({32'd0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin u = {32'd0, a} * {32'd0, b}; return u[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (ovf) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b);
    if (f3[2] && (b == 32'd0)) return 1;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Issue one op, scramble inputs while busy, check latency and write-back
  task automatic run_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] r,
                        input logic [31:0] exp, input int exp_lat);
    int lat;
    bit seen;
    @(negedge clk);
    funct3 = f3; rs1 = a; rs2 = b; rd = r; start = 1'b1;
    @(negedge clk);
    start = 1'b0; rs1 = $urandom; rs2 = $urandom; rd = 5'($urandom); funct3 = 3'($urandom);
    lat = 1; seen = 1'b0;
    while (!seen && lat <= 40) begin
      if (done) seen = 1'b1;
      else begin @(negedge clk); lat++; end
    end
    chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, " wd"}, wd, exp);
    chk({nm, " wa"}, 32'(wa), 32'(r));
    chk({nm, " en"}, 32'(en), 32'(r != 5'd0));
    chk({nm, " busy in done"}, 32'(busy), 32'd1);
    @(negedge clk);
    chk({nm, " done pulse"}, 32'(done), 32'd0);
    chk({nm, " en pulse"}, 32'(en), 32'd0);
    chk({nm, " busy after"}, 32'(busy), 32'd0);
    chk({nm, " wd held"}, wd, exp);
  endtask

  initial begin
    int dn, en_cnt;
    logic [31:0] exp_h;
    logic [2:0] f3;
    logic [31:0] a, b;
    logic [4:0] r;

    tbl[0]  = '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'h0000_0001, 33};
    tbl[1]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'h0000_0000, 33};
    tbl[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, 33};
    tbl[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, 33};
    tbl[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         5'd9,  32'hFFFF_FFFD, 33};
    tbl[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFF, 33};
    tbl[6]  = '{3'd5, 32'd100,       32'd7,         5'd11, 32'd14,        33};
    tbl[7]  = '{3'd7, 32'd100,       32'd7,         5'd12, 32'd2,         33};
    tbl[8]  = '{3'd5, 32'h1234,      32'd0,         5'd13, 32'hFFFF_FFFF, 1};
    tbl[9]  = '{3'd6, 32'h1234,      32'd0,         5'd14, 32'h0000_1234, 1};
    tbl[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1};
    tbl[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h0000_0000, 1};
    tbl[12] = '{3'd0, 32'd1234,      32'd5678,      5'd0,  32'd7006652,   33};
    tbl[13] = '{3'd4, 32'h8000_0000, 32'd1,         5'd31, 32'h8000_0000, 33};
    tbl[14] = '{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd1,  32'd0,         33};

    // Reset held with start asserted: nothing may be accepted
    rst = 1'b1; start = 1'b1; funct3 = 3'd5; rs1 = 32'd5; rs2 = 32'd0; rd = 5'd3;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset en", 32'(en), 32'd0);
      chk("reset wd", wd, 32'd0);
      chk("reset wa", 32'(wa), 32'd0);
    end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("post-reset busy", 32'(busy), 32'd0);
    chk("post-reset done", 32'(done), 32'd0);

    for (int i = 0; i < 15; i++)
      run_op($sformatf("tbl%0d", i), tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].rd,
             tbl[i].exp, tbl[i].lat);

    // start held every cycle with toggling operands: exactly one done
    @(negedge clk);
    funct3 = 3'd0; rs1 = 32'h0001_2345; rs2 = 32'h0000_1003; rd = 5'd7; start = 1'b1;
    exp_h = model(3'd0, 32'h0001_2345, 32'h0000_1003);
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        dn++;
        chk("hs wd", wd, exp_h);
        chk("hs cycle", 32'(i + 1), 32'd33);
      end
      rs1 = $urandom; rs2 = $urandom; funct3 = 3'd0;
      start = (i < 32);
    end
    chk("hs done count", 32'(dn), 32'd1);

    // Reset in the middle of a DIV abandons it without a write
    @(negedge clk);
    funct3 = 3'd4; rs1 = 32'hFFFF_FC18; rs2 = 32'd7; rd = 5'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst busy", 32'(busy), 32'd0);
    dn = 0; en_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dn++;
      if (en) en_cnt++;
    end
    chk("midrst done count", 32'(dn), 32'd0);
    chk("midrst en count", 32'(en_cnt), 32'd0);
    run_op("divu after rst", 3'd5, 32'd9, 32'd3, 5'd4, 32'd3, 33);

    // Randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      r  = 5'($urandom);
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'h8000_0000;
        default: ;
      endcase
      run_op($sformatf("rnd%0d f3=%0d", i, f3), f3, a, b, r, model(f3, a, b),
             model_lat(f3, a, b));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/otter_muldiv.md
# otter_muldiv

Iterative RV32M multiply/divide unit for the OTTER core. It sits directly downstream of the register file, consuming the `rs1`/`rs2` read data. Its registered result feeds back into the register file write port through `wa`/`wd`/`en`. It computes one M-extension operation per start handshake: 32 iteration cycles, or a one-cycle fast path for divide special cases.

## Interface
Parameters:
- `XLEN`, 32, operand/result width; only 32 is supported.

Ports:
- `clk`  input  1  clock; all state changes on the rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `start`  input  1  request; sampled only when `busy`=0.
- `funct3`  input  3  op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `rs1`  input  32  operand A, taken from the register file `rs1` output.
- `rs2`  input  32  operand B, taken from the register file `rs2` output.
- `rd`  input  5  destination register index.
- `busy`  output  1  high from the cycle after accept until the cycle `done` is high, inclusive.
- `done`  output  1  one-cycle pulse; `wd`, `wa`, `en` are valid in this cycle.
- `wd`  output  32  result, drives register file `wd`.
- `wa`  output  5  latched `rd`, drives register file `wa`.
- `en`  output  1  write enable = `done` AND (`wa` != 0).

## Operation
- States:
  - IDLE: the only state in which a start is accepted.
  - RUN: 32 iterations.
  - FIN: one cycle.
- **IDLE, `start`=1:**
  - Latch `rs1`, `rs2`, `funct3`, `rd`.
  - Set the iteration counter to 0.
  - Go to RUN, unless a fast path applies; then go directly to FIN with the fast result.
- **Fast paths (DIV/DIVU/REM/REMU only):**
  - Divisor 0: quotient = 0xFFFFFFFF, remainder = `rs1`.
  - Signed DIV/REM with `rs1`=0x80000000 and `rs2`=0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- **Sign handling:**
  - Operands are reduced to unsigned magnitudes at accept.
  - rs1 is treated as signed for MULH, MULHSU, DIV, REM.
  - rs2 is treated as signed for MULH, DIV, REM.
  - Magnitude of 0x80000000 is 2^31, held in 33 bits internally.
- **Multiply:** shift-add, one multiplier bit per cycle, into a 64-bit unsigned accumulator.
  - Negate the 64-bit product when the operand signs differ.
  - MUL returns bits [31:0]; MULH, MULHSU, MULHU return bits [63:32].
- **Divide:** restoring division, one quotient bit per cycle, with a 33-bit partial remainder.
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of `rs1`.
- RUN: the counter increments each cycle. After iteration 31 completes, go to FIN.
- FIN:
  - `done`=1 and `wd` holds the final result.
  - Return to IDLE on the next edge.
  - A `start` during FIN is ignored.
- Operands are latched at accept, so register file changes while `busy`=1 have no effect.
- `start` while `busy`=1 is ignored; there is no queueing.
- `rd`=0: the operation completes normally with `done`=1, but `en` stays 0 (x0 is never written).
- Reset mid-operation: the operation is abandoned with no write, and the unit returns to IDLE.

## Timing
- Reset values:
  - State IDLE.
  - `busy`=0, `done`=0, `en`=0.
  - `wd`=0, `wa`=0.
  - Counter 0.
- Accept edge = E0, the edge at which `start`=1 is sampled in IDLE.
- Normal latency:
  - `busy`=1 from E0 until after E33.
  - `done`, `en`, `wd` are valid in the cycle following E32 (33 cycles after accept).
  - IDLE again after E33.
- Fast-path latency:
  - `done` in the cycle following E0.
  - `busy` high for that single cycle.
  - IDLE after E1.
- Back-to-back: the earliest next accept is the edge after the `done` cycle, i.e. issue interval 34 cycles (normal) or 2 cycles (fast path).
- `wd` holds its value after `done` until the next FIN. `done` and `en` are high for exactly one cycle.
- `rst` has priority over `start` on the same edge.

## Test plan
- **Reset:** hold `rst` 2 cycles with `start`=1 -> `busy`=0, `done`=0, `en`=0, `wd`=0 throughout; no accept occurs.
- **MUL/MULH:**
  - MUL 0xFFFFFFFF × 0xFFFFFFFF, rd=5 -> `done` 33 cycles after accept, `wd`=0x00000001, `wa`=5, `en`=1.
  - MULH on the same operands -> 0x00000000.
  - MULHU on the same operands -> 0xFFFFFFFE.
- **Signed divide:**
  - DIV −7/2 -> 0xFFFFFFFD (−3).
  - REM −7/2 -> 0xFFFFFFFF (−1).
  - DIVU 100/7 -> 14.
  - REMU 100/7 -> 2.
- **Fast paths:**
  - DIVU 0x1234/0 -> 0xFFFFFFFF with `done` one cycle after accept.
  - REM 0x1234/0 -> 0x1234.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM 0x80000000/0xFFFFFFFF -> 0.
- **Handshake:**
  - `start` pulsed every cycle during a MUL -> exactly one `done`, and operands are unchanged by the `rs1`/`rs2` toggling.
  - MUL with rd=0 -> `done`=1, `en`=0.
- **Reset mid-op:** assert `rst` at iteration 10 of a DIV -> no `done` and no `en`; a fresh DIVU 9/3 accepted after reset -> 3.
